// File: rtl/beam_pkg.sv
// Shared definitions for the time-multiplexed beamformer combiner.
// Holds default sizes, the packed channel-slice helper, the output
// shift/saturate function and the sequencer state encoding.
package beam_pkg;

  localparam int unsigned BEAM_N_CH = 4;
  localparam int unsigned BEAM_DW   = 18;
  localparam int unsigned BEAM_AW   = 2 * BEAM_DW + 1 + $clog2(BEAM_N_CH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } beam_state_e;

  // LSB offset of channel k inside a packed N_CH*dw sample vector.
  function automatic int unsigned chan_lsb(input int unsigned k, input int unsigned dw);
    chan_lsb = k * dw;
  endfunction

  // Floor-shift a Q2.(2dw-2) accumulator back to Q1.(dw-1) and clamp
  // into the signed dw-bit range. Works on a 64-bit carrier so any
  // accumulator up to 64 bits can be passed in sign-extended.
  function automatic logic signed [63:0] sat_shift(input logic signed [63:0] acc,
                                                   input int unsigned dw);
    logic signed [63:0] sh;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sh = acc >>> (dw - 1);
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sh > hi) begin
      sat_shift = hi;
    end else if (sh < lo) begin
      sat_shift = lo;
    end else begin
      sat_shift = sh;
    end
  endfunction

endpackage

// File: rtl/cmac_conj.sv
// Registered conjugate complex multiply: p = conj(w) * u, 1-cycle latency.
// Ports: clk, rst (async active-high), wI/wQ weight, uI/uQ sample,
//        pI/pQ full-precision product (2*DW+1 bits).
module cmac_conj #(
  parameter int unsigned DW = 18
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic signed [DW-1:0]   wI,
  input  logic signed [DW-1:0]   wQ,
  input  logic signed [DW-1:0]   uI,
  input  logic signed [DW-1:0]   uQ,
  output logic signed [2*DW:0]   pI,
  output logic signed [2*DW:0]   pQ
);

  localparam int unsigned PW = 2 * DW + 1;

  logic signed [PW-1:0] p_i_d, p_q_d;
  logic signed [PW-1:0] p_i_q, p_q_q;

  // Operands widened first so both partial-product sums keep full precision.
  always_comb begin
    p_i_d = PW'(wI) * PW'(uI) + PW'(wQ) * PW'(uQ);
    p_q_d = PW'(wI) * PW'(uQ) - PW'(wQ) * PW'(uI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_i_q <= '0;
      p_q_q <= '0;
    end else begin
      p_i_q <= p_i_d;
      p_q_q <= p_q_d;
    end
  end

  assign pI = p_i_q;
  assign pQ = p_q_q;

endmodule

// File: rtl/beam_sum_sched.sv
// Time-multiplexed beamformer combiner: y = sum_k conj(w_k) * u_k using a
// single registered complex multiplier stepped by a small sequencer.
// Ports: clk, rst (async active-high); in_valid/in_ready + uinI/uinQ sample
//        vector; w_we/w_addr/wI/wQ weight write; out_valid/out_ready +
//        yI/yQ combined output; busy while not idle.
module beam_sum_sched
  import beam_pkg::*;
#(
  parameter int unsigned N_CH = BEAM_N_CH,
  parameter int unsigned DW   = BEAM_DW,
  parameter int unsigned AW   = 2 * DW + 1 + $clog2(N_CH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_CH*DW-1:0]            uinI,
  input  logic [N_CH*DW-1:0]            uinQ,
  input  logic                          w_we,
  input  logic [$clog2(N_CH)-1:0]       w_addr,
  input  logic signed [DW-1:0]          wI,
  input  logic signed [DW-1:0]          wQ,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DW-1:0]          yI,
  output logic signed [DW-1:0]          yQ,
  output logic                          busy
);

  localparam int unsigned KW = $clog2(N_CH);
  localparam int unsigned PW = 2 * DW + 1;

  beam_state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          accept_c;

  logic signed [DW-1:0] wbank_i_q [N_CH];
  logic signed [DW-1:0] wbank_q_q [N_CH];
  logic signed [DW-1:0] shadow_i_q [N_CH];
  logic signed [DW-1:0] shadow_q_q [N_CH];
  logic [N_CH*DW-1:0]   ucap_i_q, ucap_q_q;

  logic                 mv_q;
  logic signed [AW-1:0] acc_i_q, acc_q_q, acc_i_d, acc_q_d;
  logic signed [AW-1:0] sum_i_c, sum_q_c;
  logic signed [DW-1:0] y_i_q, y_q_q, y_i_d, y_q_d;

  logic signed [DW-1:0] mw_i, mw_q, mu_i, mu_q;
  logic signed [PW-1:0] p_i, p_q;

  assign accept_c  = in_valid && (state_q == ST_IDLE);
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_HOLD);
  assign busy      = (state_q != ST_IDLE);
  assign yI        = y_i_q;
  assign yQ        = y_q_q;

  // Sequencer state and channel counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_ISSUE;
          k_d     = '0;
        end
      end
      ST_ISSUE: begin
        k_d = k_q + KW'(1);
        if (k_q == KW'(N_CH - 1)) begin
          state_d = ST_DRAIN;
          k_d     = '0;
        end
      end
      ST_DRAIN: state_d = ST_HOLD;
      ST_HOLD:  if (out_ready) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Live weight bank, shadow snapshot and sample capture. A write landing in
  // the accept cycle is forwarded into the shadow so it is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        wbank_i_q[i]  <= '0;
        wbank_q_q[i]  <= '0;
        shadow_i_q[i] <= '0;
        shadow_q_q[i] <= '0;
      end
      ucap_i_q <= '0;
      ucap_q_q <= '0;
    end else begin
      if (w_we) begin
        wbank_i_q[w_addr] <= wI;
        wbank_q_q[w_addr] <= wQ;
      end
      if (accept_c) begin
        for (int unsigned i = 0; i < N_CH; i++) begin
          if (w_we && (w_addr == KW'(i))) begin
            shadow_i_q[i] <= wI;
            shadow_q_q[i] <= wQ;
          end else begin
            shadow_i_q[i] <= wbank_i_q[i];
            shadow_q_q[i] <= wbank_q_q[i];
          end
        end
        ucap_i_q <= uinI;
        ucap_q_q <= uinQ;
      end
    end
  end

  always_comb begin
    mw_i = shadow_i_q[k_q];
    mw_q = shadow_q_q[k_q];
    mu_i = ucap_i_q[chan_lsb(32'(k_q), DW) +: DW];
    mu_q = ucap_q_q[chan_lsb(32'(k_q), DW) +: DW];
  end

  cmac_conj #(.DW(DW)) u_cmac (
    .clk (clk),
    .rst (rst),
    .wI  (mw_i),
    .wQ  (mw_q),
    .uI  (mu_i),
    .uQ  (mu_q),
    .pI  (p_i),
    .pQ  (p_q)
  );

  // Products arrive one cycle after issue; the DRAIN cycle folds in the
  // last one and the final sum goes straight into the output register.
  always_comb begin
    sum_i_c = acc_i_q + AW'(p_i);
    sum_q_c = acc_q_q + AW'(p_q);
    acc_i_d = acc_i_q;
    acc_q_d = acc_q_q;
    y_i_d   = y_i_q;
    y_q_d   = y_q_q;
    if (accept_c) begin
      acc_i_d = '0;
      acc_q_d = '0;
    end else if (mv_q) begin
      acc_i_d = sum_i_c;
      acc_q_d = sum_q_c;
    end
    if (state_q == ST_DRAIN) begin
      y_i_d = DW'(sat_shift(64'(sum_i_c), DW));
      y_q_d = DW'(sat_shift(64'(sum_q_c), DW));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mv_q    <= 1'b0;
      acc_i_q <= '0;
      acc_q_q <= '0;
      y_i_q   <= '0;
      y_q_q   <= '0;
    end else begin
      mv_q    <= (state_q == ST_ISSUE);
      acc_i_q <= acc_i_d;
      acc_q_q <= acc_q_d;
      y_i_q   <= y_i_d;
      y_q_q   <= y_q_d;
    end
  end

endmodule
